hazard_scoreboard: RTL and testbench
====================================

HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 Parameter MULT_CYC, default 5, E-stage busy cycles for mult/multu/madd.
REQ-002 Parameter DIV_CYC, default 10, E-stage busy cycles for div/divu.
REQ-003 Parameter CNT_W, default 16, width of stall statistics counter.
REQ-004 One clock; reset is asynchronous and active-high: clk input 1, rising-edge clock; reset input 1, asynchronous active-high reset.
REQ-005 Tuse_RS_D input 2: cycles until D instr needs rs (0,1,2; 3 = rs unused).
REQ-006 Tuse_RT_D input 2: same for rt.
REQ-007 rs_D, rt_D input 5 each: source register fields of D instr.
REQ-008 issue_D input 1: D holds a valid instruction.
REQ-009 wr_en_D input 1: D instr writes GPR.
REQ-010 wr_addr_D input 5: destination GPR.
REQ-011 tnew_D input 2: cycles after entering E until the result is forwardable (0 link-PC, 1 ALU, 2 DM/mfc0).
REQ-012 md_op_D input 2: 00 none, 01 mult-class, 10 div-class, 11 other HI/LO access (mfhi/mflo/mthi/mtlo).
REQ-013 eret_D input 1: D instr is eret.
REQ-014 epc_wr_D input 1: D instr is mtc0 to EPC (CP0 reg 14).
REQ-015 Stall_PC, Stall_D, Flush_E output 1 each: freeze PC, freeze D, bubble E.
REQ-016 md_busy output 1: HI/LO unit busy.
REQ-017 stall_cnt output CNT_W: total stalled cycles.

Function
REQ-018 Three shadow entries E, M, W, each {valid, addr[4:0], tnew[1:0], epc}, SHALL track in-flight writers.
REQ-019 Each clk edge with stall=0: E <= D entry (valid = issue_D & ((wr_en_D & wr_addr_D!=0) | epc_wr_D), tnew = tnew_D, epc = epc_wr_D); M <= E with tnew = max(tnew-1,0); W <= M with tnew = 0.
REQ-020 Edge with stall=1: E <= invalid bubble; M and W advance as in REQ-019.
REQ-021 Register 0 SHALL never produce a GPR hazard.
REQ-022 Stall_RS = issue_D & Tuse_RS_D!=3 & OR over S in {E,M}: valid_S & addr_S==rs_D & addr_S!=0 & tnew_S > Tuse_RS_D; Stall_RT likewise with rt_D.
REQ-023 W entries never stall (register file write-through bypass).
REQ-024 md counter (width covering max(MULT_CYC,DIV_CYC)): loads MULT_CYC/DIV_CYC on an edge where md_op_D is 01/10, issue_D=1, stall=0; else decrements to 0 and holds.
REQ-025 md_busy = (counter != 0); Stall_MD = issue_D & md_op_D!=00 & md_busy.
REQ-026 Stall_ERET = issue_D & eret_D & ((valid_E & epc_E) | (valid_M & epc_M)).
REQ-027 Stall_D = Stall_RS | Stall_RT | Stall_MD | Stall_ERET, combinational from inputs and state; Stall_PC = Flush_E = Stall_D.
REQ-028 A stalled md_op start SHALL NOT load the counter; it loads on the first non-stalled edge.
REQ-029 stall_cnt increments by 1 on each edge with Stall_D=1, saturating at all-ones.

Reset
REQ-030 Reset asserted: all shadow entries invalid, md counter 0, stall_cnt 0, hence Stall_* = 0 and md_busy = 0, immediately and asynchronously.
REQ-031 Reset mid-divide SHALL abort the count; first cycle after release md_busy = 0.

Verification
REQ-032 lw $5 issued (tnew 2), next D = beq $5,$0 (Tuse_RS 0) -> Stall_D=1 two cycles, stall_cnt=2, no stall on third cycle.
REQ-033 addu $3 (tnew 1), next D = addu using $3 with Tuse 1 -> Stall_D=0; with Tuse 0 (jr $3) -> exactly one stall cycle.
REQ-034 Writer to $0 with tnew 2 followed by beq $0 -> Stall_D=0.
REQ-035 div issued, DIV_CYC=10; mflo arrives next cycle -> Stall_D=1 for 10 cycles, md_busy falls after 10th decrement; mult during busy also stalls and loads MULT_CYC once accepted.
REQ-036 mtc0 EPC then eret -> eret stalls 2 cycles (E then M), released when entry reaches W.
REQ-037 Reset asserted at cycle 4 of divide and during a load hazard -> all outputs 0 same cycle, stall_cnt 0, no residual stall after release.

Source files
------------

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: stall/flush control for a 5-stage MIPS pipeline. It tracks in-flight
// GPR/EPC writers in E/M/W shadow entries and keeps a HI/LO busy countdown.
module hazard_scoreboard #(
  parameter int MULT_CYC = 5,
  parameter int DIV_CYC  = 10,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       Tuse_RS_D,
  input  logic [1:0]       Tuse_RT_D,
  input  logic [4:0]       rs_D,
  input  logic [4:0]       rt_D,
  input  logic             issue_D,
  input  logic             wr_en_D,
  input  logic [4:0]       wr_addr_D,
  input  logic [1:0]       tnew_D,
  input  logic [1:0]       md_op_D,
  input  logic             eret_D,
  input  logic             epc_wr_D,
  output logic             Stall_PC,
  output logic             Stall_D,
  output logic             Flush_E,
  output logic             md_busy,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int MD_MAX = (MULT_CYC > DIV_CYC) ? MULT_CYC : DIV_CYC;
  localparam int MD_W   = $clog2(MD_MAX + 1);

  typedef struct packed {
    logic       valid;
    logic [4:0] addr;
    logic [1:0] tnew;
    logic       epc;
  } entry_t;

  entry_t           e_q, e_d, m_q, m_d;
  logic             w_valid_q, w_valid_d;
  logic [4:0]       w_addr_q, w_addr_d;
  logic [MD_W-1:0]  md_cnt_q, md_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic             stall_rs, stall_rt, stall_md, stall_eret, stall;

  function automatic logic gpr_hit(input logic valid, input logic [4:0] addr,
                                   input logic [1:0] tnew, input logic [4:0] src,
                                   input logic [1:0] tuse);
    return valid && (addr == src) && (addr != 5'd0) && (tnew > tuse);
  endfunction

  // W always carries tnew 0, so its term can never fire: the register file bypasses it.
  always_comb begin
    stall_rs = issue_D && (Tuse_RS_D != 2'd3) &&
               (gpr_hit(e_q.valid, e_q.addr, e_q.tnew, rs_D, Tuse_RS_D) ||
                gpr_hit(m_q.valid, m_q.addr, m_q.tnew, rs_D, Tuse_RS_D) ||
                gpr_hit(w_valid_q, w_addr_q, 2'd0, rs_D, Tuse_RS_D));
    stall_rt = issue_D && (Tuse_RT_D != 2'd3) &&
               (gpr_hit(e_q.valid, e_q.addr, e_q.tnew, rt_D, Tuse_RT_D) ||
                gpr_hit(m_q.valid, m_q.addr, m_q.tnew, rt_D, Tuse_RT_D) ||
                gpr_hit(w_valid_q, w_addr_q, 2'd0, rt_D, Tuse_RT_D));
    stall_md   = issue_D && (md_op_D != 2'b00) && (md_cnt_q != '0);
    stall_eret = issue_D && eret_D && ((e_q.valid && e_q.epc) || (m_q.valid && m_q.epc));
    stall      = stall_rs || stall_rt || stall_md || stall_eret;
  end

  always_comb begin
    e_d = '0;
    if (!stall) begin
      e_d.valid = issue_D && ((wr_en_D && (wr_addr_D != 5'd0)) || epc_wr_D);
      e_d.addr  = wr_addr_D;
      e_d.tnew  = tnew_D;
      e_d.epc   = epc_wr_D;
    end

    m_d      = e_q;
    m_d.tnew = (e_q.tnew != 2'd0) ? (e_q.tnew - 2'd1) : 2'd0;

    w_valid_d = m_q.valid;
    w_addr_d  = m_q.addr;

    // A start that is itself stalled must not load; it retries on the next accepted edge.
    md_cnt_d = (md_cnt_q != '0) ? (md_cnt_q - MD_W'(1)) : '0;
    if (issue_D && !stall && (md_op_D == 2'b01)) begin
      md_cnt_d = MD_W'(MULT_CYC);
    end else if (issue_D && !stall && (md_op_D == 2'b10)) begin
      md_cnt_d = MD_W'(DIV_CYC);
    end

    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      e_q         <= '0;
      m_q         <= '0;
      w_valid_q   <= 1'b0;
      w_addr_q    <= 5'd0;
      md_cnt_q    <= '0;
      stall_cnt_q <= '0;
    end else begin
      e_q         <= e_d;
      m_q         <= m_d;
      w_valid_q   <= w_valid_d;
      w_addr_q    <= w_addr_d;
      md_cnt_q    <= md_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign Stall_D   = stall;
  assign Stall_PC  = stall;
  assign Flush_E   = stall;
  assign md_busy   = (md_cnt_q != '0);
  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard: directed pipeline scenarios plus randomized traffic, checked against
// an age-based model of in-flight writers and a HI/LO free-time model.
module tb_hazard_scoreboard;

  localparam int MULT_CYC = 5;
  localparam int DIV_CYC  = 10;
  localparam int CNT_W    = 6;
  localparam int CNT_MAX  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             reset;
  logic [1:0]       Tuse_RS_D, Tuse_RT_D, tnew_D, md_op_D;
  logic [4:0]       rs_D, rt_D, wr_addr_D;
  logic             issue_D, wr_en_D, eret_D, epc_wr_D;
  logic             Stall_PC, Stall_D, Flush_E, md_busy;
  logic [CNT_W-1:0] stall_cnt;

  hazard_scoreboard #(.MULT_CYC(MULT_CYC), .DIV_CYC(DIV_CYC), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .Tuse_RS_D(Tuse_RS_D), .Tuse_RT_D(Tuse_RT_D), .rs_D(rs_D), .rt_D(rt_D),
    .issue_D(issue_D), .wr_en_D(wr_en_D), .wr_addr_D(wr_addr_D), .tnew_D(tnew_D),
    .md_op_D(md_op_D), .eret_D(eret_D), .epc_wr_D(epc_wr_D),
    .Stall_PC(Stall_PC), .Stall_D(Stall_D), .Flush_E(Flush_E),
    .md_busy(md_busy), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  // An in-flight writer is remembered by the cycle it entered E; its age gives its stage.
  typedef struct {
    int         t;
    logic [4:0] addr;
    int         tnew;
    bit         epc;
  } wr_rec_t;

  wr_rec_t inflight[$];
  int      cyc = 0;
  int      mdFreeAt = 0;
  int      modelCnt = 0;
  bit      lastStall = 1'b0;
  int      checks = 0;
  int      errors = 0;

  task automatic checkOutput(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic bit srcHazard(input int addr, input int rem, input logic [1:0] tuse,
                                   input logic [4:0] src);
    return (tuse != 2'd3) && (addr != 0) && (addr == int'(src)) && (rem > int'(tuse));
  endfunction

  function automatic bit modelStall();
    bit s;
    int age, rem;
    s = 1'b0;
    foreach (inflight[i]) begin
      age = cyc - inflight[i].t;
      if (age < 0 || age > 1) continue;
      rem = inflight[i].tnew - age;
      if (rem < 0) rem = 0;
      if (srcHazard(int'(inflight[i].addr), rem, Tuse_RS_D, rs_D)) s = 1'b1;
      if (srcHazard(int'(inflight[i].addr), rem, Tuse_RT_D, rt_D)) s = 1'b1;
      if (inflight[i].epc && eret_D) s = 1'b1;
    end
    if (md_op_D != 2'b00 && cyc < mdFreeAt) s = 1'b1;
    return issue_D && s;
  endfunction

  task automatic modelEdge(input bit stalled);
    wr_rec_t rec;
    if (stalled) begin
      modelCnt = (modelCnt < CNT_MAX) ? modelCnt + 1 : CNT_MAX;
    end else if (issue_D) begin
      if ((wr_en_D && wr_addr_D != 5'd0) || epc_wr_D) begin
        rec.t = cyc + 1;
        rec.addr = wr_addr_D;
        rec.tnew = int'(tnew_D);
        rec.epc = epc_wr_D;
        inflight.push_back(rec);
      end
      if (md_op_D == 2'b01) mdFreeAt = cyc + 1 + MULT_CYC;
      else if (md_op_D == 2'b10) mdFreeAt = cyc + 1 + DIV_CYC;
    end
    cyc++;
    while (inflight.size() > 0 && inflight[0].t < cyc - 2) void'(inflight.pop_front());
  endtask

  task automatic applyStimulus(input int issue, input int wrEn, input int wrAddr, input int tnew,
                               input int tuseRs, input int rs, input int tuseRt, input int rt,
                               input int mdOp, input int eret, input int epcWr);
    issue_D = 1'(issue);
    wr_en_D = 1'(wrEn);
    wr_addr_D = 5'(wrAddr);
    tnew_D = 2'(tnew);
    Tuse_RS_D = 2'(tuseRs);
    rs_D = 5'(rs);
    Tuse_RT_D = 2'(tuseRt);
    rt_D = 5'(rt);
    md_op_D = 2'(mdOp);
    eret_D = 1'(eret);
    epc_wr_D = 1'(epcWr);
    #1;
  endtask

  task automatic nop();
    applyStimulus(0, 0, 0, 0, 3, 0, 3, 0, 0, 0, 0);
  endtask

  // Compare settled outputs with the model, then take one clock edge.
  task automatic stepCycle();
    bit expStall;
    expStall = modelStall();
    checkOutput("Stall_D", int'(Stall_D), int'(expStall));
    checkOutput("Stall_PC", int'(Stall_PC), int'(expStall));
    checkOutput("Flush_E", int'(Flush_E), int'(expStall));
    checkOutput("md_busy", int'(md_busy), int'(cyc < mdFreeAt));
    checkOutput("stall_cnt", int'(stall_cnt), modelCnt);
    lastStall = expStall;
    @(posedge clk);
    modelEdge(expStall);
    #1;
  endtask

  task automatic applyReset();
    reset = 1'b1;
    #1;
    checkOutput("rst_Stall_D", int'(Stall_D), 0);
    checkOutput("rst_Stall_PC", int'(Stall_PC), 0);
    checkOutput("rst_Flush_E", int'(Flush_E), 0);
    checkOutput("rst_md_busy", int'(md_busy), 0);
    checkOutput("rst_stall_cnt", int'(stall_cnt), 0);
    inflight.delete();
    mdFreeAt = 0;
    modelCnt = 0;
    lastStall = 1'b0;
    @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    checkOutput("post_rst_Stall_D", int'(Stall_D), 0);
    checkOutput("post_rst_md_busy", int'(md_busy), 0);
  endtask

  task automatic randomStim();
    int r, md;
    r = $urandom_range(0, 9);
    md = (r < 6) ? 0 : (r < 7) ? 1 : (r < 8) ? 2 : 3;
    applyStimulus(int'($urandom_range(0, 9) != 0), $urandom_range(0, 1), $urandom_range(0, 7),
                  $urandom_range(0, 2), $urandom_range(0, 3), $urandom_range(0, 7),
                  $urandom_range(0, 3), $urandom_range(0, 7), md,
                  int'($urandom_range(0, 9) == 0), int'($urandom_range(0, 9) == 0));
  endtask

  initial begin
    reset = 1'b0;
    nop();
    applyReset();

    // lw $5 then beq $5: two stalls
    applyStimulus(1, 1, 5, 2, 3, 0, 3, 0, 0, 0, 0);
    checkOutput("lw_issue", int'(Stall_D), 0);
    stepCycle();
    applyStimulus(1, 0, 0, 0, 0, 5, 0, 0, 0, 0, 0);
    checkOutput("beq_stall1", int'(Stall_D), 1);
    stepCycle();
    checkOutput("beq_stall2", int'(Stall_D), 1);
    stepCycle();
    checkOutput("beq_release", int'(Stall_D), 0);
    checkOutput("beq_cnt", int'(stall_cnt), 2);
    stepCycle();

    // addu $3 then consumer with Tuse 1, then jr $3 with Tuse 0
    applyStimulus(1, 1, 3, 1, 3, 0, 3, 0, 0, 0, 0);
    stepCycle();
    applyStimulus(1, 1, 4, 1, 1, 3, 3, 0, 0, 0, 0);
    checkOutput("addu_tuse1", int'(Stall_D), 0);
    stepCycle();
    applyStimulus(1, 1, 3, 1, 3, 0, 3, 0, 0, 0, 0);
    stepCycle();
    applyStimulus(1, 0, 0, 0, 0, 3, 3, 0, 0, 0, 0);
    checkOutput("jr_stall", int'(Stall_D), 1);
    stepCycle();
    checkOutput("jr_release", int'(Stall_D), 0);
    stepCycle();

    // writer to $0 never hazards
    applyStimulus(1, 1, 0, 2, 3, 0, 3, 0, 0, 0, 0);
    stepCycle();
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("r0_no_stall", int'(Stall_D), 0);
    stepCycle();

    // div then mflo: ten stalls
    applyStimulus(1, 0, 0, 0, 3, 0, 3, 0, 2, 0, 0);
    stepCycle();
    applyStimulus(1, 1, 8, 1, 3, 0, 3, 0, 3, 0, 0);
    for (int i = 0; i < DIV_CYC; i++) begin
      checkOutput("mflo_div_stall", int'(Stall_D), 1);
      checkOutput("div_busy", int'(md_busy), 1);
      stepCycle();
    end
    checkOutput("mflo_release", int'(Stall_D), 0);
    checkOutput("div_idle", int'(md_busy), 0);
    stepCycle();

    // mult behind a busy div waits, then loads MULT_CYC
    applyStimulus(1, 0, 0, 0, 3, 0, 3, 0, 2, 0, 0);
    stepCycle();
    applyStimulus(1, 0, 0, 0, 3, 0, 3, 0, 1, 0, 0);
    for (int i = 0; i < DIV_CYC; i++) begin
      checkOutput("mult_wait", int'(Stall_D), 1);
      stepCycle();
    end
    checkOutput("mult_accept", int'(Stall_D), 0);
    stepCycle();
    applyStimulus(1, 1, 9, 1, 3, 0, 3, 0, 3, 0, 0);
    for (int i = 0; i < MULT_CYC; i++) begin
      checkOutput("mflo_mult_stall", int'(Stall_D), 1);
      stepCycle();
    end
    checkOutput("mflo_mult_release", int'(Stall_D), 0);
    stepCycle();

    // mtc0 EPC then eret: stalls while the write is in E and M
    applyStimulus(1, 0, 0, 0, 3, 0, 3, 0, 0, 0, 1);
    stepCycle();
    applyStimulus(1, 0, 0, 0, 3, 0, 3, 0, 0, 1, 0);
    checkOutput("eret_stall_E", int'(Stall_D), 1);
    stepCycle();
    checkOutput("eret_stall_M", int'(Stall_D), 1);
    stepCycle();
    checkOutput("eret_release", int'(Stall_D), 0);
    stepCycle();

    // reset during a divide and a load hazard
    applyStimulus(1, 0, 0, 0, 3, 0, 3, 0, 2, 0, 0);
    stepCycle();
    applyStimulus(1, 1, 7, 2, 3, 0, 3, 0, 0, 0, 0);
    stepCycle();
    nop();
    stepCycle();
    applyStimulus(1, 0, 0, 0, 0, 7, 3, 0, 3, 0, 0);
    checkOutput("pre_rst_stall", int'(Stall_D), 1);
    checkOutput("pre_rst_busy", int'(md_busy), 1);
    applyReset();
    applyStimulus(1, 0, 0, 0, 3, 0, 3, 0, 3, 0, 0);
    checkOutput("post_rst_mflo", int'(Stall_D), 0);
    stepCycle();

    // randomized traffic; stalled instructions are usually held in D
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 299) == 0) begin
        randomStim();
        applyReset();
        continue;
      end
      if (lastStall && $urandom_range(0, 3) != 0) #1;
      else randomStim();
      stepCycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
